rf_alu_sequencer: RTL
=====================

Name: rf_alu_sequencer

Overview:
- Multi-cycle execution sequencer that sits directly downstream of the 4x8 register file.
- Accepts one instruction at a time over a valid/ready handshake.
- For each instruction: drives the register file's two read ports, computes an ALU result, and writes it back through the register file's write port.
- Provides the register file's only write path in the datapath; reports completion and zero/carry flags to the controller.

Parameters:
- DATA_W, 8, register and ALU data width.
- ADDR_W, 2, register address width (2^ADDR_W registers).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction presented.
- instr_ready  out  1  sequencer can accept an instruction.
- instr_op  in  4  opcode.
- instr_rd  in  ADDR_W  destination register.
- instr_rs1  in  ADDR_W  source register 1.
- instr_rs2  in  ADDR_W  source register 2.
- instr_imm  in  DATA_W  immediate, used by LDI only.
- rf_read_addr1  out  ADDR_W  to register file read port 1.
- rf_read_addr2  out  ADDR_W  to register file read port 2.
- rf_read_data1  in  DATA_W  combinational read data from port 1.
- rf_read_data2  in  DATA_W  combinational read data from port 2.
- rf_we  out  1  register file write enable.
- rf_write_addr  out  ADDR_W  register file write address.
- rf_write_data  out  DATA_W  register file write data.
- done  out  1  one-cycle pulse when the instruction retires.
- err  out  1  valid with done; 1 = illegal opcode.
- flag_z  out  1  sticky zero flag, result == 0.
- flag_c  out  1  sticky carry/borrow flag.

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE from any state. Any in-flight instruction is dropped with no write.
- Reset values: instr_ready=1, rf_we=0, done=0, err=0, flag_z=0, flag_c=0, rf_write_addr=0, rf_write_data=0, rf_read_addr1/2=0.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready: latch op, rd, rs1, rs2, imm; go to READ.
- READ:
  - instr_ready=0.
  - rf_read_addr1=rs1 and rf_read_addr2=rs2, driven from the latched fields.
  - Capture rf_read_data1/2 into operand registers A/B at the edge; go to EXEC.
- EXEC:
  - Compute the result into a DATA_W+1 internal sum; go to WB.
  - ADD 0000: A+B, C=carry-out.
  - SUB 0001: A-B, C=borrow (A<B).
  - AND 0010, OR 0011, XOR 0100: C=0.
  - SHL 0101: A<<1, C=A[DATA_W-1].
  - SHR 0110: A>>1 logical, C=A[0].
  - LDI 0111: result=imm, C=0.
  - Results are truncated to DATA_W; wrap-around is allowed.
- WB:
  - Legal op: rf_we=1 for exactly this cycle, rf_write_addr=rd, rf_write_data=result. Update flag_z/flag_c at the edge.
  - Illegal op: rf_we=0, flags unchanged, err=1.
  - done=1 this cycle; go to IDLE.
- Outside WB: rf_we, done and err are 0.
- Latency: handshake at edge N, write edge and done at the edge ending cycle N+3. Throughput is one instruction per 4 cycles.
- instr_valid with instr_ready=0 is ignored; the upstream must hold it until accepted.
- rd may equal rs1/rs2: operands are captured in READ, so the write-back never corrupts the operands.
- Flags hold their value until the next legal retire.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 1000 MUL, result = low DATA_W bits of A*B, C=1 if the high DATA_W bits are nonzero. The multiplier output is registered in EXEC, so latency is unchanged.
- Undefined: 1000 is illegal like 1001-1111 (done with err=1, no write, flags unchanged).

Test Plan:
- Reset then LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 -> r3=0x80, flag_c=0, flag_z=0. rf_we pulses exactly 3 cycles after each handshake.
- LDI r0,0xFF; LDI r1,0x01; ADD r0,r0,r1 -> r0=0x00, flag_z=1, flag_c=1. Same-register read/write is correct.
- SUB r2,r1,r0 with r1=0x05, r0=0x09 -> r2=0xFC, flag_c=1. SHR of 0x03 -> 0x01, flag_c=1.
- Opcode 1011 -> done=1, err=1, rf_we never asserted, flags keep their prior values.
- instr_valid held high continuously -> instr_ready low for READ/EXEC/WB, one acceptance per 4 cycles. Assert rst during EXEC -> no write, instr_ready=1 the next cycle, flags=0.
- With ALU_MUL_EN: MUL of 0x10*0x10 -> 0x00, flag_c=1, flag_z=1. Without it, the same op gives err=1.

Source files
------------

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: multi-cycle READ/EXEC/WB sequencer in front of the 4x8 register file.
// Accepts one instruction per valid/ready handshake and reads both operands.
// It computes the ALU result, then writes the result back to the register file.
// It also keeps sticky zero/carry flags.
// Optional feature macro: ALU_MUL_EN.
//   When defined, opcode 1000 is MUL.
//   When undefined, opcode 1000 is an illegal opcode.
module rf_alu_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs1,
  input  logic [ADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              done,
  output logic              err,
  output logic              flag_z,
  output logic              flag_c
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b0111;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        op_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic              carry_reg;

  // ALU result: the low DATA_W bits are the value, and the top bit is the carry/borrow.
  logic [DATA_W:0]   alu_sum;
  logic              alu_legal;

`ifdef ALU_MUL_EN
  // Full-width product; only the low half is written back, and the high half feeds carry.
  logic [2*DATA_W-1:0] mul_prod;
  assign mul_prod = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, b_reg};
`endif

  // Combinational ALU over the captured operands; unknown opcodes are flagged illegal.
  always_comb begin
    alu_sum   = '0;
    alu_legal = 1'b1;
    case (op_reg)
      OP_ADD:  alu_sum = {1'b0, a_reg} + {1'b0, b_reg};
      OP_SUB:  alu_sum = {1'b0, a_reg} - {1'b0, b_reg};   // top bit set exactly when A < B
      OP_AND:  alu_sum = {1'b0, a_reg & b_reg};
      OP_OR:   alu_sum = {1'b0, a_reg | b_reg};
      OP_XOR:  alu_sum = {1'b0, a_reg ^ b_reg};
      OP_SHL:  alu_sum = {a_reg, 1'b0};
      OP_SHR:  alu_sum = {a_reg[0], 1'b0, a_reg[DATA_W-1:1]};
      OP_LDI:  alu_sum = {1'b0, imm_reg};
`ifdef ALU_MUL_EN
      OP_MUL:  alu_sum = {|mul_prod[2*DATA_W-1:DATA_W], mul_prod[DATA_W-1:0]};
`endif
      default: alu_legal = 1'b0;
    endcase
  end

  // Sequencer FSM; every output is a register and is updated one state ahead of its use.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      instr_ready   <= 1'b1;
      rf_we         <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      flag_z        <= 1'b0;
      flag_c        <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_read_addr1 <= '0;
      rf_read_addr2 <= '0;
      op_reg        <= '0;
      rd_reg        <= '0;
      imm_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            op_reg        <= instr_op;
            rd_reg        <= instr_rd;
            imm_reg       <= instr_imm;
            // The read-address registers double as the latched rs1/rs2 fields.
            rf_read_addr1 <= instr_rs1;
            rf_read_addr2 <= instr_rs2;
            instr_ready   <= 1'b0;
            state         <= S_READ;
          end
        end
        S_READ: begin
          // Operands are captured here, so a later write to rd cannot disturb them.
          a_reg <= rf_read_data1;
          b_reg <= rf_read_data2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (alu_legal) begin
            rf_write_addr <= rd_reg;
            rf_write_data <= alu_sum[DATA_W-1:0];
            carry_reg     <= alu_sum[DATA_W];
          end
          rf_we <= alu_legal;
          err   <= ~alu_legal;
          done  <= 1'b1;
          state <= S_WB;
        end
        S_WB: begin
          // Flags follow only legal retires; an illegal op leaves them untouched.
          if (rf_we) begin
            flag_z <= (rf_write_data == '0);
            flag_c <= carry_reg;
          end
          rf_we       <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b0;
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
